serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 22 ++
 rtl/serial_subtractor_full_subtractor.sv | 18 +
 rtl/serial_subtractor.sv | 138 +++++++++++++
 tb/tb_serial_subtractor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding and the single-bit subtraction equations.
package serial_subtractor_pkg;

  // Operation sequencing for serial arithmetic units.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } serial_state_e;

  // Borrow generated by one bit of a - b - bin.
  function automatic logic borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

  // Difference bit of a - b - bin.
  function automatic logic diff_bit(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, bout = borrow.
module full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Purely combinational difference and borrow.
  always_comb begin
    d    = diff_bit(a, b, bin);
    bout = borrow(a, b, bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit unsigned subtractor: input1 - input2, one bit per clock,
// LSB first, through one full-subtractor cell and a borrow flop.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] answer,
  output logic         borrow_out,
  output logic         zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  serial_state_e state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  w_q, w_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          brw_q, brw_d;
  logic [N-1:0]  answer_q, answer_d;
  logic          borrow_out_q, borrow_out_d;
  logic          zero_q, zero_d;

  logic          d_bit;
  logic          bout_bit;
  logic [N:0]    w_ext;
  logic [N-1:0]  w_shift;

  // The one shared arithmetic cell, fed from the operand LSBs.
  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (brw_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // W shifted right with the fresh difference bit entering at the MSB;
  // written as a wide shift so it stays legal for N=1.
  always_comb begin
    w_ext   = {d_bit, w_q} >> 1;
    w_shift = w_ext[N-1:0];
  end

  // Next-state, datapath and result-register update logic.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    w_d          = w_q;
    cnt_d        = cnt_q;
    brw_d        = brw_q;
    answer_d     = answer_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = input1;
          b_d     = input2;
          w_d     = '0;
          cnt_d   = '0;
          brw_d   = 1'b0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        w_d   = w_shift;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = bout_bit;
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish the complete result in the same edge so the
        // outputs never expose a partially built W.
        if (cnt_q == LAST_BIT) begin
          answer_d     = w_shift;
          borrow_out_d = bout_bit;
          zero_d       = (w_shift == '0);
          state_d      = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and result registers; reset aborts any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      w_q          <= '0;
      cnt_q        <= '0;
      brw_q        <= 1'b0;
      answer_q     <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      w_q          <= w_d;
      cnt_q        <= cnt_d;
      brw_q        <= brw_d;
      answer_q     <= answer_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
    end
  end

  // Status and result outputs come straight from registers.
  always_comb begin
    busy       = (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    answer     = answer_q;
    borrow_out = borrow_out_q;
    zero       = zero_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random
// operands, checked against plain-arithmetic expectations.
module tb_serial_subtractor;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset;

  logic          start;
  logic [N-1:0]  in1, in2;
  logic          busy, done, borrow_out, zero;
  logic [N-1:0]  answer;

  logic          start_s;
  logic [0:0]    in1_s, in2_s;
  logic          busy_s, done_s, borrow_out_s, zero_s;
  logic [0:0]    answer_s;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.N(N)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .input1     (in1),
    .input2     (in2),
    .busy       (busy),
    .done       (done),
    .answer     (answer),
    .borrow_out (borrow_out),
    .zero       (zero)
  );

  serial_subtractor #(.N(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .start      (start_s),
    .input1     (in1_s),
    .input2     (in2_s),
    .busy       (busy_s),
    .done       (done_s),
    .answer     (answer_s),
    .borrow_out (borrow_out_s),
    .zero       (zero_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete N=32 operation with latency, busy-length and result checks.
  task automatic run32(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0]   ext;
    logic [N-1:0] exp_ans;
    int           busy_cnt;
    int           cyc;
    ext     = {1'b0, a} - {1'b0, b};
    exp_ans = ext[N-1:0];
    in1   = a;
    in2   = b;
    start = 1'b1;
    tick();
    start    = 1'b0;
    busy_cnt = 0;
    cyc      = 0;
    while (!done && cyc < N + 4) begin
      if (busy) busy_cnt++;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(N));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(N));
    check({tag, "_answer"}, 64'(answer), 64'(exp_ans));
    check({tag, "_borrow"}, 64'(borrow_out), 64'(a < b));
    check({tag, "_zero"}, 64'(zero), 64'(a == b));
    tick();
    check({tag, "_done_fall"}, 64'(done), 64'd0);
    $display("op %s: 0x%08h - 0x%08h -> answer=0x%08h borrow=%0b zero=%0b",
             tag, a, b, answer, borrow_out, zero);
  endtask

  // One complete N=1 operation.
  task automatic run1(input string tag, input logic a, input logic b);
    int cyc;
    in1_s   = a;
    in2_s   = b;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cyc     = 0;
    while (!done_s && cyc < 5) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd1);
    check({tag, "_answer"}, 64'(answer_s), 64'(a ^ b));
    check({tag, "_borrow"}, 64'(borrow_out_s), 64'(!a && b));
    check({tag, "_zero"}, 64'(zero_s), 64'(a == b));
    tick();
    $display("op %s: %0b - %0b -> answer=%0b borrow=%0b zero=%0b",
             tag, a, b, answer_s, borrow_out_s, zero_s);
  endtask

  initial begin
    int done_cnt;
    int done_cyc;
    int busy_late;
    logic [N-1:0] seen_ans;
    logic [N-1:0] ra, rb;

    reset   = 1'b1;
    start   = 1'b0;
    in1     = '0;
    in2     = '0;
    start_s = 1'b0;
    in1_s   = '0;
    in2_s   = '0;
    tick();
    tick();

    // Reset state.
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_answer", 64'(answer), 64'd0);
    check("rst_borrow", 64'(borrow_out), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_busy_n1", 64'(busy_s), 64'd0);
    reset = 1'b0;
    tick();

    // Directed operations.
    run32("100_minus_37", 32'd100, 32'd37);
    check("100_minus_37_const", 64'(answer), 64'd63);
    run32("5_minus_7", 32'd5, 32'd7);
    check("5_minus_7_const", 64'(answer), 64'hFFFF_FFFE);
    run32("deadbeef_self", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // start during RUN and during DONE must be ignored.
    in1   = 32'd9;
    in2   = 32'd4;
    start = 1'b1;
    tick();
    start     = 1'b0;
    done_cnt  = 0;
    done_cyc  = -1;
    busy_late = 0;
    seen_ans  = '0;
    for (int cyc = 1; cyc <= N + 40; cyc++) begin
      tick();
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        seen_ans = answer;
      end
      if (cyc > N + 1 && busy) busy_late++;
      if (cyc == 3) begin
        in1   = 32'd1;
        in2   = 32'd2;
        start = 1'b1;
      end
      if (cyc == 4) start = 1'b0;
      if (cyc == N) start = 1'b1;
      if (cyc == N + 1) start = 1'b0;
    end
    check("ignore_done_count", 64'(done_cnt), 64'd1);
    check("ignore_done_cycle", 64'(done_cyc), 64'(N));
    check("ignore_answer", 64'(seen_ans), 64'd5);
    check("ignore_answer_held", 64'(answer), 64'd5);
    check("ignore_no_restart", 64'(busy_late), 64'd0);
    $display("op ignore_start: 9 - 4 -> answer=%0d done_count=%0d", answer, done_cnt);

    // Asynchronous reset in the middle of an operation.
    in1   = 32'd200;
    in2   = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #1 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_answer", 64'(answer), 64'd0);
    check("abort_borrow", 64'(borrow_out), 64'd0);
    check("abort_zero", 64'(zero), 64'd0);
    repeat (3) tick();
    reset    = 1'b0;
    done_cnt = 0;
    for (int cyc = 0; cyc < N + 8; cyc++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    $display("op abort: 200 - 1 aborted, outputs cleared");
    run32("8_minus_8", 32'd8, 32'd8);

    // Random operands; every fourth pair is equal to exercise zero.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      run32($sformatf("rand%0d", i), ra, rb);
    end

    // N=1 with start held high: a new operation every 3 cycles.
    in1_s   = 1'b0;
    in2_s   = 1'b1;
    start_s = 1'b1;
    tick();
    check("n1_busy_e0", 64'(busy_s), 64'd1);
    in1_s = 1'b1;
    in2_s = 1'b0;
    tick();
    check("n1_first_done", 64'(done_s), 64'd1);
    check("n1_first_answer", 64'(answer_s), 64'd1);
    check("n1_first_borrow", 64'(borrow_out_s), 64'd1);
    $display("op n1_first: 0 - 1 -> answer=%0b borrow=%0b", answer_s, borrow_out_s);
    tick();
    check("n1_idle_gap", 64'(done_s | busy_s), 64'd0);
    tick();
    check("n1_second_busy", 64'(busy_s), 64'd1);
    tick();
    check("n1_second_done", 64'(done_s), 64'd1);
    check("n1_second_answer", 64'(answer_s), 64'd1);
    check("n1_second_borrow", 64'(borrow_out_s), 64'd0);
    $display("op n1_second: 1 - 0 -> answer=%0b borrow=%0b", answer_s, borrow_out_s);
    start_s = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 8; i++) begin
      run1($sformatf("n1_rand%0d", i), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
